seg_addsub_pipe: RTL and testbench

//  Parametrised segmented add/subtract pipeline with elastic valid/ready flow control.
//  - A WIDTH-bit operation is split into NSEG = WIDTH/SEG_W segments.
//  - Stage k adds segment k and registers the carry for stage k+1.
//  - Operand high parts, the partial sum and a TAG_W sideband travel with the data.
//  - Used by the square-root datapath for the restoring add/sub step; it replaces the

---
 rtl/seg_addsub_pipe.sv | 168 ++++++++++++++++
 tb/tb_seg_addsub_pipe.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/seg_addsub_pipe.sv
// -----------------------------------------------------------------------------
// seg_addsub_pipe
//   Segmented add/subtract pipeline with elastic valid/ready flow control.
//   A WIDTH-bit operation is split into NSEG = WIDTH/SEG_W segments. Stage k
//   adds segment k and registers its carry for stage k+1. The operand bits not
//   yet consumed, the growing partial sum and a TAG_W sideband travel with
//   the data. B is inverted at entry for subtraction, and sub_i is the carry-in.
//
// Ports
//   clk, rst_n     clock (rising edge), asynchronous active-low reset
//   flush_i        synchronous flush of every in-flight operation
//   in_valid_i     operand valid          in_ready_o   operand accepted
//   a_i, b_i       operands               sub_i        0: A+B, 1: A-B
//   tag_i          sideband in            tag_o        sideband out
//   out_valid_o    result valid           out_ready_i  consumer takes result
//   sum_o          result mod 2^WIDTH     co_o         carry out (sub: 1 = A>=B)
//   count_o        number of occupied stages
//
// Handshake: a transfer happens on a rising edge where valid and ready are both
// high. valid never depends on ready. Once out_valid_o is high, the result is
// held stable until it is taken. in_ready_o is low whenever flush_i is high.
// -----------------------------------------------------------------------------
module seg_addsub_pipe #(
    parameter int WIDTH = 16,
    parameter int SEG_W = 8,
    parameter int TAG_W = 2
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               flush_i,
    input  logic                               in_valid_i,
    output logic                               in_ready_o,
    input  logic [WIDTH-1:0]                   a_i,
    input  logic [WIDTH-1:0]                   b_i,
    input  logic                               sub_i,
    input  logic [TAG_W-1:0]                   tag_i,
    output logic                               out_valid_o,
    input  logic                               out_ready_i,
    output logic [WIDTH-1:0]                   sum_o,
    output logic                               co_o,
    output logic [TAG_W-1:0]                   tag_o,
    output logic [$clog2(WIDTH/SEG_W+1)-1:0]   count_o
);

    localparam int NSEG  = WIDTH / SEG_W;
    localparam int CNT_W = $clog2(NSEG + 1);

    logic [NSEG-1:0]  r_valid;
    logic [NSEG-1:0]  w_ready;   // stage k may load this cycle
    logic [NSEG-1:0]  w_vin;     // valid arriving at stage k
    logic [CNT_W-1:0] w_cnt;

    // The ready chain is walked from the output back using a scalar
    // accumulator, so no vector bit depends on another bit of the same vector.
    always_comb begin
        logic w_rdy;
        w_rdy   = out_ready_i;
        w_ready = '0;
        for (int k = NSEG - 1; k >= 0; k--) begin
            w_rdy      = !r_valid[k] | w_rdy;
            w_ready[k] = w_rdy;
        end
    end

    always_comb begin
        w_vin    = '0;
        w_vin[0] = in_valid_i;
        for (int k = 1; k < NSEG; k++) begin
            w_vin[k] = r_valid[k-1];
        end
    end

    always_comb begin
        w_cnt = '0;
        for (int k = 0; k < NSEG; k++) begin
            w_cnt = w_cnt + CNT_W'(r_valid[k]);
        end
    end

    // Flush wins over every load. Data registers are left as they are.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= '0;
        end else if (flush_i) begin
            r_valid <= '0;
        end else begin
            for (int k = 0; k < NSEG; k++) begin
                if (w_ready[k]) begin
                    r_valid[k] <= w_vin[k];
                end
            end
        end
    end

    for (genvar k = 0; k < NSEG; k++) begin : g_stage
        localparam int LO_W = (k + 1) * SEG_W;   // sum bits resolved so far
        localparam int HI_W = WIDTH - LO_W;      // operand bits still pending

        logic [LO_W-1:0]  r_sum;
        logic             r_carry;
        logic [TAG_W-1:0] r_tag;

        logic [SEG_W:0]   w_seg;                 // {carry, segment sum}
        logic [LO_W-1:0]  w_sum_nxt;
        logic [TAG_W-1:0] w_tag_nxt;

        if (k == 0) begin : g_src
            assign w_seg     = {1'b0, a_i[SEG_W-1:0]}
                             + {1'b0, b_i[SEG_W-1:0] ^ {SEG_W{sub_i}}}
                             + {{SEG_W{1'b0}}, sub_i};
            assign w_sum_nxt = w_seg[SEG_W-1:0];
            assign w_tag_nxt = tag_i;
        end else begin : g_src
            // Lowest pending segment of the previous stage, plus its carry.
            assign w_seg     = {1'b0, g_stage[k-1].g_hi.r_a[SEG_W-1:0]}
                             + {1'b0, g_stage[k-1].g_hi.r_b[SEG_W-1:0]}
                             + {{SEG_W{1'b0}}, g_stage[k-1].r_carry};
            assign w_sum_nxt = {w_seg[SEG_W-1:0], g_stage[k-1].r_sum};
            assign w_tag_nxt = g_stage[k-1].r_tag;
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_sum   <= '0;
                r_carry <= 1'b0;
                r_tag   <= '0;
            end else if (w_ready[k] && w_vin[k]) begin
                r_sum   <= w_sum_nxt;
                r_carry <= w_seg[SEG_W];
                r_tag   <= w_tag_nxt;
            end
        end

        // The last stage has no pending operand bits.
        if (HI_W > 0) begin : g_hi
            logic [HI_W-1:0] r_a;
            logic [HI_W-1:0] r_b;                // already inverted for sub
            logic [HI_W-1:0] w_a_nxt;
            logic [HI_W-1:0] w_b_nxt;

            if (k == 0) begin : g_hsrc
                assign w_a_nxt = a_i[WIDTH-1:SEG_W];
                assign w_b_nxt = b_i[WIDTH-1:SEG_W] ^ {HI_W{sub_i}};
            end else begin : g_hsrc
                assign w_a_nxt = g_stage[k-1].g_hi.r_a[HI_W+SEG_W-1:SEG_W];
                assign w_b_nxt = g_stage[k-1].g_hi.r_b[HI_W+SEG_W-1:SEG_W];
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_a <= '0;
                    r_b <= '0;
                end else if (w_ready[k] && w_vin[k]) begin
                    r_a <= w_a_nxt;
                    r_b <= w_b_nxt;
                end
            end
        end
    end

    assign in_ready_o  = w_ready[0] & !flush_i;
    assign out_valid_o = r_valid[NSEG-1];
    assign sum_o       = g_stage[NSEG-1].r_sum;
    assign co_o        = g_stage[NSEG-1].r_carry;
    assign tag_o       = g_stage[NSEG-1].r_tag;
    assign count_o     = w_cnt;

endmodule

// File: tb/tb_seg_addsub_pipe.sv
module tb_seg_addsub_pipe;

  localparam int WIDTH = 16;
  localparam int SEG_W = 8;
  localparam int TAG_W = 2;
  localparam int RW    = WIDTH + TAG_W + 1;   // {co, tag, sum}

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic             flush_i, in_valid_i, in_ready_o, sub_i;
  logic [WIDTH-1:0] a_i, b_i, sum_o;
  logic [TAG_W-1:0] tag_i, tag_o;
  logic             out_valid_o, out_ready_i, co_o;
  logic [1:0]       count_o;

  seg_addsub_pipe #(.WIDTH(WIDTH), .SEG_W(SEG_W), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst_n(rst_n), .flush_i(flush_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .a_i(a_i), .b_i(b_i), .sub_i(sub_i), .tag_i(tag_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .sum_o(sum_o), .co_o(co_o), .tag_o(tag_o), .count_o(count_o)
  );

  // ---------------- checking ----------------
  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [RW-1:0] model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                          input logic s, input logic [TAG_W-1:0] t);
    logic [WIDTH:0] r;
    if (s) r = {1'b0, a} + {1'b0, ~b} + 1;
    else   r = {1'b0, a} + {1'b0, b};
    return {r[WIDTH], t, r[WIDTH-1:0]};
  endfunction

  // ---------------- scoreboard ----------------
  logic [RW-1:0] exp_q[$];
  bit            mon_en = 1'b0;
  int            n_deliv = 0;

  always @(negedge clk) begin
    if (mon_en && rst_n) begin
      if (out_valid_o && out_ready_i) begin
        n_deliv++;
        if (exp_q.size() == 0) chk("unexpected_out", 32'd1, 32'd0);
        else                   chk("result", {co_o, tag_o, sum_o}, exp_q.pop_front());
      end
      if (flush_i) exp_q.delete();
      else if (in_valid_i && in_ready_o) exp_q.push_back(model(a_i, b_i, sub_i, tag_i));
    end
  end

  // ---------------- drivers ----------------
  logic [WIDTH-1:0] op_a[16];
  logic [WIDTH-1:0] op_b[16];
  logic             op_s[16];
  logic [TAG_W-1:0] op_t[16];
  int n_ops = 0;
  int idx   = 0;

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic drive_op(input int i);
    a_i = op_a[i]; b_i = op_b[i]; sub_i = op_s[i]; tag_i = op_t[i];
    in_valid_i = 1'b1;
  endtask

  task automatic feed(input int n_cyc, input bit chk_rdy);
    for (int c = 0; c < n_cyc; c++) begin
      @(negedge clk);
      if (chk_rdy) chk("in_ready_full", in_ready_o, 1);
      if (in_valid_i && in_ready_o) idx++;
      @(posedge clk); #1;
      if (idx < n_ops) drive_op(idx);
      else in_valid_i = 1'b0;
    end
  endtask

  // Offer one op until accepted, then check the result one cycle later.
  task automatic send_chk(input string tag, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          input logic s, input logic [TAG_W-1:0] t,
                          input logic [WIDTH-1:0] exp_sum, input logic exp_co);
    bit ok;
    ok = 1'b0;
    a_i = a; b_i = b; sub_i = s; tag_i = t; in_valid_i = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (in_ready_o) begin ok = 1'b1; break; end
      @(posedge clk);
    end
    @(posedge clk); #1;
    in_valid_i = 1'b0;
    if (!ok) chk({tag, "_timeout"}, 32'd0, 32'd1);
    step();
    chk({tag, "_valid"}, out_valid_o, 1);
    chk({tag, "_sum"}, sum_o, exp_sum);
    chk({tag, "_co"}, co_o, exp_co);
    chk({tag, "_tag"}, tag_o, t);
  endtask

  // ---------------- test sequence ----------------
  int d0;
  logic [RW-1:0] e0;

  initial begin
    rst_n = 1'b0; flush_i = 1'b0; in_valid_i = 1'b0; out_ready_i = 1'b1;
    a_i = '0; b_i = '0; sub_i = 1'b0; tag_i = '0;

    // 1. reset
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", out_valid_o, 0);
    chk("rst_sum", sum_o, 0);
    chk("rst_count", count_o, 0);
    rst_n = 1'b1;
    #1;
    chk("rst_in_ready", in_ready_o, 1);
    out_ready_i = 1'b0;
    a_i = 16'hFFFF; b_i = 16'h0002; tag_i = 2'b11; in_valid_i = 1'b1;
    step(); step();
    chk("pre_rst_count", count_o, 2);
    chk("pre_rst_valid", out_valid_o, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", out_valid_o, 0);
    chk("arst_sum", sum_o, 0);
    chk("arst_co", co_o, 0);
    chk("arst_tag", tag_o, 0);
    chk("arst_count", count_o, 0);
    in_valid_i = 1'b0; out_ready_i = 1'b1;
    step();
    rst_n = 1'b1;
    repeat (3) step();
    chk("post_rst_valid", out_valid_o, 0);
    chk("post_rst_count", count_o, 0);

    mon_en = 1'b1;

    // 2./3. directed arithmetic
    send_chk("carry_x_seg", 16'h00FF, 16'h0001, 1'b0, 2'b10, 16'h0100, 1'b0);
    send_chk("add_wrap",    16'hFFFF, 16'h0001, 1'b0, 2'b01, 16'h0000, 1'b1);
    send_chk("sub_noborrow",16'h0100, 16'h0001, 1'b1, 2'b00, 16'h00FF, 1'b1);
    send_chk("sub_borrow",  16'h0001, 16'h0002, 1'b1, 2'b11, 16'hFFFF, 1'b0);
    step();

    // 4. back-pressure with 6 random ops
    for (int i = 0; i < 6; i++) begin
      op_a[i] = 16'($urandom_range(0, 65535));
      op_b[i] = 16'($urandom_range(0, 65535));
      op_s[i] = 1'($urandom_range(0, 1));
      op_t[i] = 2'($urandom_range(0, 3));
    end
    n_ops = 6; idx = 0; out_ready_i = 1'b0;
    drive_op(0);
    feed(5, 1'b0);
    e0 = model(op_a[0], op_b[0], op_s[0], op_t[0]);
    chk("bp_accepts", idx, 2);
    chk("bp_in_ready", in_ready_o, 0);
    chk("bp_count", count_o, 2);
    chk("bp_valid", out_valid_o, 1);
    chk("bp_hold_sum", sum_o, e0[WIDTH-1:0]);
    step(); step();
    chk("bp_hold_sum2", sum_o, e0[WIDTH-1:0]);
    chk("bp_hold_co", co_o, e0[RW-1]);
    out_ready_i = 1'b1;
    d0 = n_deliv;
    feed(6, 1'b0);
    chk("bp_drain_deliv", n_deliv - d0, 6);
    chk("bp_drain_q", exp_q.size(), 0);

    // 5. full-rate streaming
    for (int i = 0; i < 12; i++) begin
      op_a[i] = 16'(16'h1357 * (i + 1));
      op_b[i] = 16'(16'h2468 + i * 16'h0F0F);
      op_s[i] = 1'(i % 2);
      op_t[i] = 2'(i % 4);
    end
    n_ops = 12; idx = 0;
    drive_op(0);
    d0 = n_deliv;
    feed(12, 1'b1);
    chk("stream_accepts", idx, 12);
    chk("stream_deliv", n_deliv - d0, 10);
    repeat (3) step();
    chk("stream_q", exp_q.size(), 0);

    // 6. flush with 2 ops in flight and an input offered
    op_a[0] = 16'h0A0A; op_b[0] = 16'h0101; op_s[0] = 1'b0; op_t[0] = 2'b01;
    op_a[1] = 16'h5555; op_b[1] = 16'h1111; op_s[1] = 1'b1; op_t[1] = 2'b10;
    op_a[2] = 16'h7777; op_b[2] = 16'h0001; op_s[2] = 1'b0; op_t[2] = 2'b11;
    n_ops = 3; idx = 0;
    drive_op(0);
    feed(2, 1'b0);
    chk("fl_inflight", count_o, 2);
    flush_i = 1'b1;
    #1;
    chk("fl_in_ready", in_ready_o, 0);
    step();
    flush_i = 1'b0; in_valid_i = 1'b0;
    chk("fl_valid", out_valid_o, 0);
    chk("fl_count", count_o, 0);
    repeat (3) step();
    chk("fl_no_ghost", out_valid_o, 0);
    send_chk("post_flush", 16'h1234, 16'h1111, 1'b0, 2'b01, 16'h2345, 1'b0);
    repeat (2) step();
    chk("final_q", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
